// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared debounce state encoding and default timing constant
package lab_pkg;

    // Debounce FSM states; bit 1 doubles as the accepted level.
    typedef enum logic [1:0] {
        ST_LOW      = 2'b00,
        ST_CHK_HIGH = 2'b01,
        ST_HIGH     = 2'b11,
        ST_CHK_LOW  = 2'b10
    } db_state_e;

    // 1 ms of stability at a 50 MHz system clock.
    localparam int STABLE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch channel: 2-flop synchronizer, stability counter, debounce FSM
module debounce_channel
    import lab_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Catch impossible parameterisations while elaborating, not in silicon.
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES must be at least 1");
    end
    if (64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
        $error("debounce_channel: CNT_W too narrow to hold STABLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state logic: synchronizer shift plus the four-state acceptance FSM.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s2_q) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHK_HIGH: begin
                if (!s2_q) begin
                    // Bounce shorter than the window: drop it without a trace.
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHK_LOW: begin
                if (s2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any half-qualified candidate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two independent debounced switch channels feeding the a/b lab inputs
module button_conditioner
    import lab_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_level,
    output logic b_level,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_raw),
        .level (a_level),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .level (b_level),
        .rise  (b_rise),
        .fall  (b_fall)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner at STABLE_CYCLES=4
module tb_button_conditioner;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a_level, b_level, a_rise, a_fall, b_rise, b_fall;

    int n_cmp;
    int n_bad;

    button_conditioner #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_level (a_level),
        .b_level (b_level),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {a_level, a_rise, a_fall, b_level, b_rise, b_fall}
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {a_level, a_rise, a_fall, b_level, b_rise, b_fall};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to the next falling edge (sampling point, and input drive point).
    task automatic tick();
        @(negedge clk);
    endtask

    // n-1 cycles showing 'quiet', then cycle n showing 'hit'.
    task automatic wait_check(input string tag, input int n,
                              input logic [5:0] quiet, input logic [5:0] hit);
        for (int i = 1; i < n; i++) begin
            tick();
            chk(tag, quiet);
        end
        tick();
        chk(tag, hit);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;

        // Reset held 3 cycles with both raws high: everything stays 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", 6'b000000);
        end
        rst_n = 1'b1;
        // Both channels re-qualify from LOW: 7 cycles after release.
        wait_check("reset_release", 7, 6'b000000, 6'b110110);
        tick();
        chk("reset_after", 6'b100100);

        // Simultaneous release of both switches.
        a_raw = 1'b0;
        b_raw = 1'b0;
        wait_check("simul_fall", 7, 6'b100100, 6'b001001);
        tick();
        chk("simul_after", 6'b000000);
        tick();
        chk("simul_settled", 6'b000000);

        // Clean press on A, B untouched.
        a_raw = 1'b1;
        wait_check("clean_press", 7, 6'b000000, 6'b110000);
        tick();
        chk("clean_after", 6'b100000);

        // Return A to low so the bounce starts from LOW.
        a_raw = 1'b0;
        wait_check("a_release", 7, 6'b100000, 6'b001000);
        tick();
        chk("a_release_after", 6'b000000);

        // Bounce 1,0,1,0 in single-cycle steps, then hold 1.
        a_raw = 1'b1; tick(); chk("bounce", 6'b000000);
        a_raw = 1'b0; tick(); chk("bounce", 6'b000000);
        a_raw = 1'b1; tick(); chk("bounce", 6'b000000);
        a_raw = 1'b0; tick(); chk("bounce", 6'b000000);
        a_raw = 1'b1;
        wait_check("bounce_rise", 7, 6'b000000, 6'b110000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bounce_after", 6'b100000);
        end

        // Bring B high for the glitch test.
        b_raw = 1'b1;
        wait_check("b_press", 7, 6'b100000, 6'b100110);
        tick();
        chk("b_press_after", 6'b100100);

        // 3-cycle low glitch on B from HIGH: rejected.
        b_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_low", 6'b100100);
        end
        b_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch_after", 6'b100100);
        end

        // Return A low ahead of the mid-count reset.
        a_raw = 1'b0;
        wait_check("a_release2", 7, 6'b100100, 6'b001100);
        tick();
        chk("a_release2_after", 6'b000100);

        // Press A, reset during CHK_HIGH, release with A still held.
        a_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midcnt_pre", 6'b000100);
        end
        rst_n = 1'b0;
        tick();
        chk("midcnt_rst", 6'b000000);
        tick();
        chk("midcnt_rst", 6'b000000);
        rst_n = 1'b1;
        wait_check("midcnt_requal", 7, 6'b000000, 6'b110110);
        tick();
        chk("midcnt_after", 6'b100100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Two-channel input conditioner that turns raw, asynchronous, bouncing switch inputs into clean, clock-synchronous signals for the two-input sequential lab circuit (`a`, `b`). Each channel has three stages: a 2-flop synchronizer, a stability counter and a 4-state debounce FSM. Each channel outputs a debounced level plus one-cycle rise and fall pulses. It sits directly upstream of the sequential circuit: `a_level`/`b_level` drive its `a`/`b` inputs.

## Interface
- `STABLE_CYCLES`, default 50000: consecutive identical synchronized samples required to accept a new level (1 ms at 50 MHz). Legal range ≥ 1.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: width of the stability counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `a_raw`  in  1  raw switch A; asynchronous and may bounce.
- `b_raw`  in  1  raw switch B; asynchronous and may bounce.
- `a_level`  out  1  debounced level of A.
- `b_level`  out  1  debounced level of B.
- `a_rise`  out  1  one-cycle pulse when `a_level` goes 0→1.
- `a_fall`  out  1  one-cycle pulse when `a_level` goes 1→0.
- `b_rise`  out  1  one-cycle pulse when `b_level` goes 0→1.
- `b_fall`  out  1  one-cycle pulse when `b_level` goes 1→0.

## Operation
- The two channels are identical and fully independent; no cross-channel interaction.
- Synchronizer: `s1 <= raw; s2 <= s1`. Only `s2` is used downstream.
- FSM states:
  - LOW: level 0.
  - CHK_HIGH: candidate 1, level still 0.
  - HIGH: level 1.
  - CHK_LOW: candidate 0, level still 1.
- LOW: if `s2`=1, go to CHK_HIGH with cnt=1; otherwise stay, cnt=0.
- CHK_HIGH:
  - If `s2`=0, return to LOW with cnt=0. This is a glitch, rejected silently.
  - Otherwise, if cnt == STABLE_CYCLES, go to HIGH, set level=1, pulse rise, cnt=0.
  - Otherwise cnt += 1.
- HIGH and CHK_LOW mirror LOW and CHK_HIGH with polarity inverted; the accepting transition pulses fall.
- STABLE_CYCLES=1: the acceptance check happens on the first cycle in CHK_*, so a single stable sample qualifies.
- cnt never exceeds STABLE_CYCLES and never wraps. CNT_W must hold STABLE_CYCLES; if it cannot, that is an elaboration-time error.
- Outputs are registered: level, rise and fall all come straight from flops, with no combinational path from inputs to outputs.
- rise and fall are never asserted together, and never in two consecutive cycles for the same channel.

## Timing
- Reset, with `rst_n`=0 at a rising edge:
  - `s1`, `s2`, cnt = 0; state = LOW.
  - All levels and pulses = 0 on the following cycle.
  - Raw inputs are ignored while reset is held.
- Reset mid-count: any in-progress CHK_* is abandoned. After release, a raw input held at 1 must re-qualify from LOW.
- Latency: raw changes and then stays stable. Edge 1 captures `s1`, edge 2 `s2`. Level and pulse change after edge 2 + STABLE_CYCLES + 1, i.e. at most STABLE_CYCLES+3 cycles after the raw change.
- Pulse width: exactly one `clk` cycle, aligned with the first cycle of the new level.
- Glitch rejection: any bounce shorter than the acceptance window produces no level change and no pulse.
- Simultaneous A and B changes are handled per channel with identical latency.

## Structure
- Shared package `lab_pkg` holds:
  - the FSM state encoding: LOW=2'b00, CHK_HIGH=2'b01, HIGH=2'b11, CHK_LOW=2'b10;
  - the default STABLE_CYCLES constant.
- Sub-module `debounce_channel` (params STABLE_CYCLES, CNT_W; ports clk, rst_n, raw, level, rise, fall) contains the synchronizer, counter and FSM.
- `button_conditioner` instantiates `debounce_channel` twice and contains no logic of its own.
- The expected RTL total is about 150 lines.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset: hold `rst_n`=0 for 3 cycles with `a_raw`=`b_raw`=1 → all outputs 0 during reset and on the first post-reset cycle. `a_level` rises 7 cycles after release.
- Clean press: `a_raw` 0→1 and held → `a_level`=1 and `a_rise`=1 for exactly one cycle, 7 cycles after the change; `b_*` stay 0.
- Bounce: `a_raw` toggles 1,0,1,0,1 in single-cycle steps, then holds 1 → one `a_rise` only, 7 cycles after the final 1; no `a_fall`.
- Short glitch: from HIGH, `b_raw`=0 for 3 cycles then back to 1 → `b_level` stays 1, and `b_fall` never asserts.
- Release plus simultaneous: both raw inputs go 1→0 on the same cycle → `a_fall` and `b_fall` both assert on the same cycle, 7 cycles later; levels read 0 afterwards.
- Reset mid-count: press A, assert `rst_n`=0 during CHK_HIGH (3 cycles after the press), release while `a_raw` is still 1 → no pulse before reset; `a_rise` 7 cycles after release.
